// File: rtl/latch_exerciser_if.sv
// +----------------------------------------------------------------------+
// | latch_exerciser_if: connection to the external level-sensitive latch |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

interface latch_exerciser_if;
  logic lat_en;
  logic lat_d;
  logic lat_q;
  logic lat_qb;

  modport master (
    output lat_en,
    output lat_d,
    input  lat_q,
    input  lat_qb
  );

  modport slave (
    input  lat_en,
    input  lat_d,
    output lat_q,
    output lat_qb
  );
endinterface

`default_nettype wire

// File: rtl/latch_exerciser.sv
// +----------------------------------------------------------------------+
// | latch_exerciser: writes a word LSB-first into an external D latch,    |
// | disturbs d after each close and checks that q/qb held the bit.        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module latch_exerciser #(
  parameter int WIDTH     = 8,
  parameter int SETUP_CYC = 1,
  parameter int OPEN_CYC  = 2,
  parameter int HOLD_CYC  = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             start,
  input  wire logic [WIDTH-1:0] data,
  input  wire logic             clr_cnt,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [7:0]            err_count,
  output logic [WIDTH-1:0]      rd_data,
  latch_exerciser_if.master     lat
);

  localparam int MAX_CYC = (SETUP_CYC > OPEN_CYC)
                         ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                         : ((OPEN_CYC > HOLD_CYC) ? OPEN_CYC : HOLD_CYC);
  localparam int CNT_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] OPEN_LAST  = CNT_W'(OPEN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_OPEN  = 3'd2,
    ST_HOLD  = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] phase_q, phase_d;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic [7:0]       err_count_q, err_count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             lat_en_q, lat_en_d;
  logic             lat_d_q, lat_d_d;
  logic             mismatch;
  logic [WIDTH-1:0] shreg_next;

  assign shreg_next = shreg_q >> 1;

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    bit_idx_d   = bit_idx_q;
    shreg_d     = shreg_q;
    rd_data_d   = rd_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    err_d       = err_q;
    lat_en_d    = lat_en_q;
    lat_d_d     = lat_d_q;
    mismatch    = 1'b0;
    err_count_d = err_count_q;

    case (state_q)
      ST_IDLE: begin
        lat_en_d = 1'b0;
        busy_d   = 1'b0;
        if (start) begin
          shreg_d   = data;
          err_d     = 1'b0;
          rd_data_d = '0;
          bit_idx_d = '0;
          phase_d   = '0;
          lat_d_d   = data[0];
          busy_d    = 1'b1;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (phase_q == SETUP_LAST) begin
          phase_d  = '0;
          lat_en_d = 1'b1;
          state_d  = ST_OPEN;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_OPEN: begin
        // en falls and d inverts on the same edge: the latch under test
        // must have zero (or negative) hold time relative to en falling.
        if (phase_q == OPEN_LAST) begin
          phase_d  = '0;
          lat_en_d = 1'b0;
          lat_d_d  = ~shreg_q[0];
          state_d  = ST_HOLD;
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (phase_q == HOLD_LAST) begin
          mismatch = (lat.lat_q != shreg_q[0]) || (lat.lat_qb == shreg_q[0]);
          if (mismatch) begin
            err_d = 1'b1;
          end
          rd_data_d[bit_idx_q] = lat.lat_q;
          phase_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
            shreg_d   = shreg_next;
            lat_d_d   = shreg_next[0];
            state_d   = ST_SETUP;
          end
        end else begin
          phase_d = phase_q + 1'b1;
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        lat_en_d = 1'b0;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase

    // Clear takes priority over a mismatch sampled on the same edge.
    if (clr_cnt) begin
      err_count_d = 8'd0;
    end else if (mismatch && (err_count_q != 8'hFF)) begin
      err_count_d = err_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_idx_q   <= '0;
      shreg_q     <= '0;
      rd_data_q   <= '0;
      err_count_q <= 8'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      lat_en_q    <= 1'b0;
      lat_d_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_idx_q   <= bit_idx_d;
      shreg_q     <= shreg_d;
      rd_data_q   <= rd_data_d;
      err_count_q <= err_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      lat_en_q    <= lat_en_d;
      lat_d_q     <= lat_d_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
  assign rd_data    = rd_data_q;
  assign lat.lat_en = lat_en_q;
  assign lat.lat_d  = lat_d_q;

endmodule

`default_nettype wire

// File: tb/tb_latch_exerciser.sv
// +----------------------------------------------------------------------+
// | tb_latch_exerciser: drives latch_exerciser against a behavioural      |
// | latch with selectable faults and checks each transaction result.      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_latch_exerciser;
  localparam int WIDTH     = 8;
  localparam int SETUP_CYC = 1;
  localparam int OPEN_CYC  = 2;
  localparam int HOLD_CYC  = 2;
  localparam int P         = SETUP_CYC + OPEN_CYC + HOLD_CYC;

  localparam int M_IDEAL  = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_TRANSP = 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [WIDTH-1:0] data;
  logic             clr_cnt;
  logic             busy;
  logic             done;
  logic             err;
  logic [7:0]       err_count;
  logic [WIDTH-1:0] rd_data;

  latch_exerciser_if lif();

  latch_exerciser #(
    .WIDTH(WIDTH), .SETUP_CYC(SETUP_CYC), .OPEN_CYC(OPEN_CYC), .HOLD_CYC(HOLD_CYC)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .data(data), .clr_cnt(clr_cnt),
    .busy(busy), .done(done), .err(err), .err_count(err_count),
    .rd_data(rd_data), .lat(lif.master)
  );

  always #5 clk = ~clk;

  // Behavioural latch under test, with injectable faults
  int   mode = M_IDEAL;
  logic held = 1'b0;

  always @(negedge clk) begin
    if (lif.lat_en) held <= lif.lat_d;
  end

  always_comb begin
    lif.lat_q  = held;
    lif.lat_qb = ~held;
    case (mode)
      M_STUCK0: begin lif.lat_q = 1'b0;       lif.lat_qb = ~held;       end
      M_TRANSP: begin lif.lat_q = lif.lat_d;  lif.lat_qb = ~lif.lat_d;  end
      default:  begin lif.lat_q = held;       lif.lat_qb = ~held;       end
    endcase
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    int unsigned      done_cyc;
    logic [WIDTH-1:0] rd;
    logic             err;
    logic [7:0]       cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   en_rises = 0;
  int   en_hi    = 0;
  int   en_idle  = 0;
  logic prev_en  = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      en_rises = 0;
      en_hi    = 0;
      prev_en  = 1'b0;
    end else begin
      if (lif.lat_en && !busy) en_idle++;
      if (lif.lat_en && !prev_en) en_rises++;
      if (lif.lat_en) en_hi++;
      prev_en = lif.lat_en;
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done: done=1 at cycle %0d, expected done=0", cyc);
        end else begin
          mon_e = sb.pop_front();
          check("done_cycle", cyc, mon_e.done_cyc);
          check("rd_data", 32'(rd_data), 32'(mon_e.rd));
          check("err", 32'(err), 32'(mon_e.err));
          check("err_count", 32'(err_count), 32'(mon_e.cnt));
          check("busy_at_done", 32'(busy), 32'd1);
          check("en_pulses", en_rises, WIDTH);
          check("en_high_cycles", en_hi, WIDTH * OPEN_CYC);
        end
        en_rises = 0;
        en_hi    = 0;
      end
    end
  end

  // Reference behaviour of each latch model for one word
  function automatic void model(input int m, input logic [WIDTH-1:0] d,
                                output logic [WIDTH-1:0] rd, output int mism);
    logic q, qb;
    mism = 0;
    rd   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      case (m)
        M_STUCK0: begin q = 1'b0;  qb = ~d[i]; end
        M_TRANSP: begin q = ~d[i]; qb = d[i];  end
        default:  begin q = d[i];  qb = ~d[i]; end
      endcase
      if ((q != d[i]) || (qb != ~d[i])) mism++;
      rd[i] = q;
    end
  endfunction

  int exp_cnt = 0;

  task automatic push_exp(input int unsigned dcyc, input logic [WIDTH-1:0] rd,
                          input logic e, input int mism);
    exp_t x;
    exp_cnt = (exp_cnt + mism > 255) ? 255 : exp_cnt + mism;
    x.done_cyc = dcyc;
    x.rd       = rd;
    x.err      = e;
    x.cnt      = 8'(exp_cnt);
    sb.push_back(x);
  endtask

  task automatic launch(input int m, input logic [WIDTH-1:0] d,
                        input logic [WIDTH-1:0] rd, input logic e, input int mism);
    @(negedge clk);
    mode  = m;
    data  = d;
    start = 1'b1;
    push_exp(cyc + 1 + WIDTH * P, rd, e, mism);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    while (sb.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL done_timeout: %0d transactions pending after %0d cycles, expected 0", sb.size(), bound);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic run_model(input int m, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] rd;
    int               mism;
    model(m, d, rd, mism);
    launch(m, d, rd, mism != 0, mism);
    wait_idle(100);
  endtask

  typedef struct {
    int               m;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] rd;
    logic             e;
    int               mism;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned c0;
    int unsigned d1;

    vecs[0] = '{M_IDEAL,  8'hA5, 8'hA5, 1'b0, 0};
    vecs[1] = '{M_STUCK0, 8'hFF, 8'h00, 1'b1, 8};
    vecs[2] = '{M_STUCK0, 8'h00, 8'h00, 1'b0, 0};
    vecs[3] = '{M_TRANSP, 8'h0F, 8'hF0, 1'b1, 8};
    vecs[4] = '{M_IDEAL,  8'h3C, 8'h3C, 1'b0, 0};
    vecs[5] = '{M_STUCK0, 8'h81, 8'h00, 1'b1, 2};

    rst     = 1'b1;
    start   = 1'b1;
    clr_cnt = 1'b1;
    data    = 8'hFF;
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err), 0);
    check("rst_err_count", 32'(err_count), 0);
    check("rst_rd_data", 32'(rd_data), 0);
    check("rst_lat_en", 32'(lif.lat_en), 0);
    check("rst_lat_d", 32'(lif.lat_d), 0);
    start   = 1'b0;
    clr_cnt = 1'b0;
    rst     = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      launch(vecs[i].m, vecs[i].d, vecs[i].rd, vecs[i].e, vecs[i].mism);
      wait_idle(100);
    end

    // start re-asserted mid-transaction must be ignored
    launch(M_IDEAL, 8'h5A, 8'h5A, 1'b0, 0);
    repeat (3) @(negedge clk);
    start = 1'b1; data = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_idle(100);

    // start held high: back-to-back with one idle cycle
    @(negedge clk);
    c0    = cyc;
    mode  = M_IDEAL;
    data  = 8'h96;
    start = 1'b1;
    d1    = c0 + 1 + WIDTH * P;
    push_exp(d1, 8'h96, 1'b0, 0);
    push_exp(d1 + 2 + WIDTH * P, 8'h96, 1'b0, 0);
    for (int n = 0; n < 100 && cyc != d1; n++) @(negedge clk);
    @(negedge clk);
    check("gap_busy_low", 32'(busy), 0);
    @(negedge clk);
    check("gap_busy_high", 32'(busy), 1);
    repeat (10) @(negedge clk);
    start = 1'b0;
    wait_idle(100);

    // reset during OPEN of bit 3
    @(negedge clk);
    mode  = M_IDEAL;
    data  = 8'hC3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (16) @(negedge clk);
    check("abort_in_open", 32'(lif.lat_en), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_lat_en", 32'(lif.lat_en), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_err_count", 32'(err_count), 0);
    check("abort_done", 32'(done), 0);
    exp_cnt = 0;
    repeat (60) @(negedge clk);
    run_model(M_IDEAL, 8'h69);

    // saturation: 31*8 + 6 = 254, then 3 more mismatches
    for (int i = 0; i < 31; i++) run_model(M_TRANSP, 8'(i * 37 + 1));
    run_model(M_STUCK0, 8'h3F);
    check("preload_254", 32'(err_count), 254);
    run_model(M_STUCK0, 8'h07);
    check("saturate_255", 32'(err_count), 255);

    // clr_cnt on the same edge as the only mismatch sample
    @(negedge clk);
    c0    = cyc;
    mode  = M_STUCK0;
    data  = 8'h01;
    start = 1'b1;
    exp_cnt = 0;
    push_exp(c0 + 1 + WIDTH * P, 8'h00, 1'b1, 0);
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    clr_cnt = 1'b1;
    @(negedge clk);
    clr_cnt = 1'b0;
    check("clr_wins", 32'(err_count), 0);
    wait_idle(100);

    check("lat_en_outside_busy", en_idle, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
